// File: rtl/pipelined_ctrl_unit.sv
// Registered decode/control stage of the RV32IM pipeline (IF/ID -> EX).
// Decodes the supported opcodes one cycle after acceptance and holds
// multi-cycle MUL/DIV operations in a small sequencer.
//
// Handshake: an instruction is taken on a rising edge when INSTR_VALID=1,
// the sequencer is IDLE, STALL_IN=0 and FLUSH=0. STALL_OUT tells IF/ID to
// hold its contents; while an MD operation is pending the IF/ID inputs are
// ignored, so upstream must keep the next instruction until STALL_OUT drops.
module pipelined_ctrl_unit #(
  parameter bit M_EXT      = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INSTR_VALID,
  input  logic [6:0] OP,
  input  logic [2:0] FUN3,
  input  logic [6:0] FUN7,
  input  logic       STALL_IN,
  input  logic       FLUSH,
  output logic [4:0] ALU_OP,
  output logic [2:0] MEM_READ,
  output logic [2:0] MEM_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_TO_REG,
  output logic       BRANCH,
  output logic       ALU_SOURCE,
  output logic       CTRL_VALID,
  output logic       ILLEGAL,
  output logic       MD_BUSY,
  output logic       STALL_OUT,
  output logic       dbg_state
);

  typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [2:0] mem_read;
    logic [2:0] mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_source;
  } ctrl_t;

  // Counter preload is L-2 so that CTRL_VALID rises exactly L edges after accept.
  localparam logic [4:0] MUL_INIT = 5'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [4:0] DIV_INIT = 5'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam bit         MUL_MC   = (MUL_CYCLES > 1);
  localparam bit         DIV_MC   = (DIV_CYCLES > 1);

  state_t     state;
  logic [4:0] cnt;
  ctrl_t      ctrl_q;

  ctrl_t      dec;
  logic       dec_ill;
  logic       dec_mc;
  logic [4:0] dec_init;

  // Combinational decode of the IF/ID fields.
  always_comb begin
    dec      = '0;
    dec_ill  = 1'b0;
    dec_mc   = 1'b0;
    dec_init = '0;
    case (OP)
      7'b0110011: begin
        if (FUN7 == 7'b0000000) begin
          dec.alu_op    = {2'b00, FUN3};
          dec.reg_write = 1'b1;
        end else if (FUN7 == 7'b0100000 && FUN3 == 3'b000) begin
          dec.alu_op    = 5'b10000;
          dec.reg_write = 1'b1;
        end else if (FUN7 == 7'b0100000 && FUN3 == 3'b101) begin
          dec.alu_op    = 5'b10101;
          dec.reg_write = 1'b1;
        end else if (FUN7 == 7'b0000001 && M_EXT) begin
          dec.alu_op    = {2'b11, FUN3};
          dec.reg_write = 1'b1;
          dec_mc        = FUN3[2] ? DIV_MC : MUL_MC;
          dec_init      = FUN3[2] ? DIV_INIT : MUL_INIT;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0010011: begin
        dec.alu_op     = {2'b00, FUN3};
        dec.alu_source = 1'b1;
        dec.reg_write  = 1'b1;
        if (FUN3 == 3'b001 && FUN7 != 7'b0000000) dec_ill = 1'b1;
        if (FUN3 == 3'b101) begin
          if (FUN7 == 7'b0100000)      dec.alu_op = 5'b10101;
          else if (FUN7 != 7'b0000000) dec_ill = 1'b1;
        end
      end
      7'b0000011: begin
        dec.alu_source = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        case (FUN3)
          3'b000:  dec.mem_read = 3'b001;
          3'b001:  dec.mem_read = 3'b010;
          3'b010:  dec.mem_read = 3'b011;
          3'b100:  dec.mem_read = 3'b100;
          3'b101:  dec.mem_read = 3'b101;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.alu_source = 1'b1;
        case (FUN3)
          3'b000:  dec.mem_write = 3'b001;
          3'b001:  dec.mem_write = 3'b010;
          3'b010:  dec.mem_write = 3'b011;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        dec.alu_op = 5'b10000;
        if (FUN3 == 3'b010 || FUN3 == 3'b011) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Control register and MD sequencer: FLUSH > STALL_IN > sequencer > accept.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_q     <= '0;
      CTRL_VALID <= 1'b0;
      ILLEGAL    <= 1'b0;
      MD_BUSY    <= 1'b0;
    end else if (FLUSH) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrl_q     <= '0;
      CTRL_VALID <= 1'b0;
      ILLEGAL    <= 1'b0;
      MD_BUSY    <= 1'b0;
    end else if (!STALL_IN) begin
      if (state == MD_WAIT) begin
        if (cnt == 5'd0) begin
          CTRL_VALID <= 1'b1;
          MD_BUSY    <= 1'b0;
          state      <= IDLE;
        end else begin
          cnt <= cnt - 5'd1;
        end
      end else if (INSTR_VALID && !dec_ill) begin
        ctrl_q  <= dec;
        ILLEGAL <= 1'b0;
        if (dec_mc) begin
          CTRL_VALID <= 1'b0;
          MD_BUSY    <= 1'b1;
          cnt        <= dec_init;
          state      <= MD_WAIT;
        end else begin
          CTRL_VALID <= 1'b1;
          MD_BUSY    <= 1'b0;
        end
      end else begin
        ctrl_q     <= '0;
        CTRL_VALID <= 1'b0;
        MD_BUSY    <= 1'b0;
        ILLEGAL    <= INSTR_VALID & dec_ill;
      end
    end
  end

  assign ALU_OP     = ctrl_q.alu_op;
  assign MEM_READ   = ctrl_q.mem_read;
  assign MEM_WRITE  = ctrl_q.mem_write;
  assign REG_WRITE  = ctrl_q.reg_write;
  assign MEM_TO_REG = ctrl_q.mem_to_reg;
  assign BRANCH     = ctrl_q.branch;
  assign ALU_SOURCE = ctrl_q.alu_source;
  assign dbg_state  = state;
  // Held low in reset so every output is 0 while RESET is asserted.
  assign STALL_OUT  = RESET & (STALL_IN | MD_BUSY);

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Testbench for pipelined_ctrl_unit: directed scenarios followed by random
// stimulus, compared against a queue-based behavioural model.
module tb_pipelined_ctrl_unit;

  localparam int MUL_L = 2;
  localparam int DIV_L = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv, stall_in, flush;
  logic [6:0] op, f7;
  logic [2:0] f3;

  logic [4:0] a_alu, b_alu;
  logic [2:0] a_mr, a_mw, b_mr, b_mw;
  logic a_rw, a_m2r, a_br, a_src, a_cv, a_ill, a_busy, a_so, a_dbg;
  logic b_rw, b_m2r, b_br, b_src, b_cv, b_ill, b_busy, b_so, b_dbg;

  pipelined_ctrl_unit #(.M_EXT(1'b1), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut_a (
    .CLK(clk), .RESET(rst_n), .INSTR_VALID(iv), .OP(op), .FUN3(f3), .FUN7(f7),
    .STALL_IN(stall_in), .FLUSH(flush), .ALU_OP(a_alu), .MEM_READ(a_mr),
    .MEM_WRITE(a_mw), .REG_WRITE(a_rw), .MEM_TO_REG(a_m2r), .BRANCH(a_br),
    .ALU_SOURCE(a_src), .CTRL_VALID(a_cv), .ILLEGAL(a_ill), .MD_BUSY(a_busy),
    .STALL_OUT(a_so), .dbg_state(a_dbg));

  pipelined_ctrl_unit #(.M_EXT(1'b0), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut_b (
    .CLK(clk), .RESET(rst_n), .INSTR_VALID(iv), .OP(op), .FUN3(f3), .FUN7(f7),
    .STALL_IN(stall_in), .FLUSH(flush), .ALU_OP(b_alu), .MEM_READ(b_mr),
    .MEM_WRITE(b_mw), .REG_WRITE(b_rw), .MEM_TO_REG(b_m2r), .BRANCH(b_br),
    .ALU_SOURCE(b_src), .CTRL_VALID(b_cv), .ILLEGAL(b_ill), .MD_BUSY(b_busy),
    .STALL_OUT(b_so), .dbg_state(b_dbg));

  // Output word: {alu5, mr3, mw3, rw, m2r, br, src, valid, ill, busy}
  logic [17:0] obs_a, obs_b;
  assign obs_a = {a_alu, a_mr, a_mw, a_rw, a_m2r, a_br, a_src, a_cv, a_ill, a_busy};
  assign obs_b = {b_alu, b_mr, b_mw, b_rw, b_m2r, b_br, b_src, b_cv, b_ill, b_busy};

  // Scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] cur_a, cur_b;
  int checks = 0;
  int errors = 0;

  // Reference decode straight from the instruction tables: {multi, illegal, word}
  function automatic logic [19:0] ref_decode(input logic [6:0] o, input logic [2:0] fn3,
                                             input logic [6:0] fn7, input bit mext);
    logic [4:0] alu;
    logic [2:0] mr, mw;
    logic rw, m2r, br, src, ill, md;
    alu = 0; mr = 0; mw = 0; rw = 0; m2r = 0; br = 0; src = 0; ill = 0; md = 0;
    case (o)
      7'h33: begin
        rw = 1;
        if (fn7 == 7'h00) alu = {2'b00, fn3};
        else if (fn7 == 7'h20 && fn3 == 3'd0) alu = 5'b10000;
        else if (fn7 == 7'h20 && fn3 == 3'd5) alu = 5'b10101;
        else if (fn7 == 7'h01 && mext) begin alu = {2'b11, fn3}; md = 1; end
        else ill = 1;
      end
      7'h13: begin
        src = 1; rw = 1; alu = {2'b00, fn3};
        if (fn3 == 3'd1 && fn7 != 7'h00) ill = 1;
        if (fn3 == 3'd5) begin
          if (fn7 == 7'h20) alu = 5'b10101;
          else if (fn7 != 7'h00) ill = 1;
        end
      end
      7'h03: begin
        src = 1; rw = 1; m2r = 1;
        case (fn3)
          3'd0: mr = 3'd1;
          3'd1: mr = 3'd2;
          3'd2: mr = 3'd3;
          3'd4: mr = 3'd4;
          3'd5: mr = 3'd5;
          default: ill = 1;
        endcase
      end
      7'h23: begin
        src = 1;
        if (fn3 <= 3'd2) mw = fn3 + 3'd1;
        else ill = 1;
      end
      7'h63: begin
        br = 1; alu = 5'b10000;
        if (fn3 == 3'd2 || fn3 == 3'd3) ill = 1;
      end
      default: ill = 1;
    endcase
    return {md, ill, alu, mr, mw, rw, m2r, br, src, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, model update, and output comparison.
  task automatic step(input logic v, input logic [6:0] o, input logic [2:0] fn3,
                      input logic [6:0] fn7, input logic st, input logic fl);
    logic [19:0] d;
    int lat;
    @(negedge clk);
    iv = v; op = o; f3 = fn3; f7 = fn7; stall_in = st; flush = fl;
    @(posedge clk);
    // Model of the M_EXT=1 unit
    if (fl) begin
      cur_a = '0;
      exp_q.delete();
    end else if (!st) begin
      if (exp_q.size() > 0) cur_a = exp_q.pop_front();
      else if (v) begin
        d = ref_decode(o, fn3, fn7, 1'b1);
        lat = fn3[2] ? DIV_L : MUL_L;
        if (d[18]) cur_a = 18'b10;
        else if (d[19] && lat > 1) begin
          cur_a = d[17:0] | 18'b1;
          for (int i = 0; i < lat - 2; i++) exp_q.push_back(d[17:0] | 18'b1);
          exp_q.push_back(d[17:0] | 18'b100);
        end else cur_a = d[17:0] | 18'b100;
      end else cur_a = '0;
    end
    // Model of the M_EXT=0 unit (never multi-cycle)
    if (fl) cur_b = '0;
    else if (!st) begin
      if (v) begin
        d = ref_decode(o, fn3, fn7, 1'b0);
        cur_b = d[18] ? 18'b10 : (d[17:0] | 18'b100);
      end else cur_b = '0;
    end
    #1;
    check("a_ctrl", 32'(obs_a), 32'(cur_a));
    check("a_stall_out", 32'(a_so), 32'(st | cur_a[0]));
    check("a_state", 32'(a_dbg), 32'(cur_a[0]));
    check("b_ctrl", 32'(obs_b), 32'(cur_b));
    check("b_stall_out", 32'(b_so), 32'(st | cur_b[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    @(negedge clk);
    stall_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_a", 32'({obs_a, a_so}), 32'd0);
    check("reset_b", 32'({obs_b, b_so}), 32'd0);
    cur_a = '0; cur_b = '0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; stall_in = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [5];
    logic [6:0] f7s [3];
    logic [6:0] ro, rf7;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    rst_n = 1'b0; iv = 0; op = 0; f3 = 0; f7 = 0; stall_in = 0; flush = 0;
    cur_a = '0; cur_b = '0;
    #1;
    check("reset_init_a", 32'({obs_a, a_so}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // SUB then LBU
    step(1, 7'h33, 3'd0, 7'h20, 0, 0);
    check("sub_alu_op", 32'(a_alu), 32'h10);
    check("sub_reg_write_valid", 32'({a_rw, a_cv}), 32'b11);
    step(1, 7'h03, 3'd4, 7'h00, 0, 0);
    check("lbu_fields", 32'({a_mr, a_m2r, a_src}), 32'b100_1_1);

    // DIV: 7 busy cycles, valid in cycle 8
    step(1, 7'h33, 3'd4, 7'h01, 0, 0);
    check("div_alu_op", 32'(a_alu), 32'h1C);
    idle(DIV_L);

    // MUL with a 3-cycle downstream stall in MD_WAIT
    step(1, 7'h33, 3'd0, 7'h01, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 7'h00, 3'd0, 7'h00, 1, 0);
    step(0, 7'h00, 3'd0, 7'h00, 0, 0);
    check("mul_valid_after_stall", 32'(a_cv), 32'd1);
    idle(1);

    // FLUSH together with STALL_IN during DIV wait
    step(1, 7'h33, 3'd5, 7'h01, 0, 0);
    idle(2);
    step(0, 7'h00, 3'd0, 7'h00, 1, 1);
    check("flush_bubble", 32'({a_cv, a_busy, a_so}), 32'b001);

    // Illegal encodings
    step(1, 7'h63, 3'd2, 7'h00, 0, 0);
    check("illegal_branch", 32'({a_ill, a_cv, a_rw}), 32'b100);
    step(1, 7'h33, 3'd1, 7'h01, 0, 0);
    check("b_illegal_mulh", 32'({b_ill, b_cv, b_rw}), 32'b100);
    idle(1);
    check("illegal_one_cycle", 32'({a_ill, b_ill}), 32'd0);

    // Back-to-back DIVs
    step(1, 7'h33, 3'd6, 7'h01, 0, 0);
    for (int i = 0; i < DIV_L - 1; i++) step(1, 7'h33, 3'd7, 7'h01, 0, 0);
    idle(DIV_L + 1);

    // Reset in the middle of an MD wait
    step(1, 7'h33, 3'd4, 7'h01, 0, 0);
    idle(3);
    async_reset();
    idle(2);

    // Random stimulus
    for (int n = 0; n < 2000; n++) begin
      ro  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      rf7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 2)];
      step(1'($urandom_range(0, 9) < 7), ro, 3'($urandom), rf7,
           1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 4));
    end
    idle(DIV_L + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
